// File: rtl/program_loader.sv
// Program RAM writer: receives a framed byte stream (sync, word count, words, optional
// XOR checksum) and fills the program RAM, holding the CPU halted until a frame loads cleanly.
// Optional checksum byte and CHECK state: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write_enable,
  output logic                  cpu_halt,
  output logic                  load_done,
  output logic                  load_error,
  output logic [3:0]            state_dbg
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready drops only in WRITE, so a held rx_valid simply waits one cycle there.

  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_COUNT_HI = 4'd1,
    S_COUNT_LO = 4'd2,
    S_DATA_HI  = 4'd3,
    S_DATA_LO  = 4'd4,
    S_WRITE    = 4'd5,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK    = 4'd6,
`endif
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t           state, state_next;
  logic [7:0]       count_hi;
  logic [CNT_W-1:0] remaining;
  logic [15:0]      count_full;
  logic             accept;
  logic             is_sync;
  logic             count_over;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  assign accept     = rx_valid && rx_ready;
  assign is_sync    = (rx_data == SYNC_BYTE);
  assign count_full = {count_hi, rx_data};
  // Rejecting counts above the RAM depth up front guarantees the address never wraps.
  assign count_over = ({16'd0, count_full} > (32'd1 << ADDR_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (accept && is_sync) state_next = S_COUNT_HI;
      S_COUNT_HI: if (accept) state_next = S_COUNT_LO;
      S_COUNT_LO: begin
        if (accept) begin
          if (count_over)               state_next = S_ERROR;
          else if (count_full == 16'd0) state_next = S_END;
          else                          state_next = S_DATA_HI;
        end
      end
      S_DATA_HI:  if (accept) state_next = S_DATA_LO;
      S_DATA_LO:  if (accept) state_next = S_WRITE;
      S_WRITE:    state_next = (remaining == CNT_W'(1)) ? S_END : S_DATA_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:    if (accept) state_next = (rx_data == checksum) ? S_DONE : S_ERROR;
`endif
      S_DONE:     if (accept && is_sync) state_next = S_COUNT_HI;
      S_ERROR:    if (accept && is_sync) state_next = S_COUNT_HI;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready         = (state != S_WRITE);
    mem_write_enable = (state == S_WRITE);
    cpu_halt         = (state != S_DONE);
    load_done        = (state == S_DONE);
    load_error       = (state == S_ERROR);
    state_dbg        = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address <= '0;
      mem_data    <= '0;
      count_hi    <= '0;
      remaining   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept && is_sync) begin
            mem_address <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
          end
        end
        S_COUNT_HI: if (accept) count_hi <= rx_data;
        S_COUNT_LO: if (accept) remaining <= count_full[CNT_W-1:0];
        S_DATA_HI: begin
          if (accept) begin
            mem_data[DATA_WIDTH-1:DATA_WIDTH/2] <= rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_data;
`endif
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            mem_data[DATA_WIDTH/2-1:0] <= rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          remaining <= remaining - CNT_W'(1);
          // Stay on the last written address rather than stepping past the top of RAM.
          if (remaining != CNT_W'(1)) mem_address <= mem_address + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte driver, write scoreboard with expected queue,
// and a final pass/total report. Build with PROGRAM_LOADER_CHECKSUM_EN to exercise checksums.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  mem_address;
  logic [15:0] mem_data;
  logic        mem_write_enable;
  logic        cpu_halt;
  logic        load_done;
  logic        load_error;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  int n_bytes  = 0;
  int n_sent   = 0;
  int n_overlap = 0;
  int cyc      = 0;
  logic [7:0]  model_cks;
  logic [25:0] exp_q[$];

  program_loader dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .cpu_halt         (cpu_halt),
    .load_done        (load_done),
    .load_error       (load_error),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) n_bytes++;
      if (mem_write_enable) begin
        n_writes++;
        if (rx_ready) n_overlap++;
        if (exp_q.size() == 0) check("unexpected_write", {6'd0, mem_address, mem_data}, 32'hFFFF_FFFF);
        else check("write", {6'd0, mem_address, mem_data}, {6'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte has transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check("rx_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    n_sent++;
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [15:0] w);
    exp_q.push_back({addr, w});
    model_cks = model_cks ^ w[15:8] ^ w[7:0];
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int c0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; model_cks = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_cpu_halt", cpu_halt, 1);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_we", mem_write_enable, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);

    // Noise bytes then a good two-word frame.
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(10'd0, 16'h8000);
    send_word(10'd1, 16'h00FF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h7F);
`endif
    idle(3);
    check("f1_done", load_done, 1);
    check("f1_error", load_error, 0);
    check("f1_halt", cpu_halt, 0);
    check("f1_writes", n_writes, 2);
    check("f1_pending", exp_q.size(), 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum: words still land, frame flagged.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(10'd0, 16'h8000);
    send_word(10'd1, 16'h00FF);
    send_byte(8'h7E);
    idle(3);
    check("bad_cks_error", load_error, 1);
    check("bad_cks_done", load_done, 0);
    check("bad_cks_halt", cpu_halt, 1);
`endif

    // Count 0x0401 exceeds 1024 words: immediate error, no writes.
    w0 = n_writes;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    idle(4);
    check("ovf_error", load_error, 1);
    check("ovf_done", load_done, 0);
    check("ovf_halt", cpu_halt, 1);
    check("ovf_writes", n_writes - w0, 0);

    // Zero-length frame restarts from ERROR and completes with no writes.
    w0 = n_writes;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(3);
    check("zero_done", load_done, 1);
    check("zero_halt", cpu_halt, 0);
    check("zero_writes", n_writes - w0, 0);

    // Back-to-back bytes with rx_valid held: only WRITE stalls the stream.
    c0 = cyc;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_word(10'd0, 16'h1122);
    send_word(10'd1, 16'h3344);
    send_word(10'd2, 16'h5566);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h77);
    check("b2b_cycles", cyc - c0, 13);
`else
    check("b2b_cycles", cyc - c0, 11);
`endif
    idle(3);
    check("b2b_done", load_done, 1);
    check("b2b_pending", exp_q.size(), 0);

    // Full 1024-word frame: top address reached without wrapping.
    w0 = n_writes;
    model_cks = 8'h00;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_word(10'(i), 16'(i * 37 + 5) ^ 16'h5A3C);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(model_cks);
`endif
    idle(3);
    check("full_writes", n_writes - w0, 1024);
    check("full_done", load_done, 1);
    check("full_last_addr", mem_address, 10'd1023);

    // Reset in the middle of a frame, then a fresh one-word frame.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03); send_byte(8'h80);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_halt", cpu_halt, 1);
    check("mid_rst_ready", rx_ready, 1);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_error", load_error, 0);
    check("mid_rst_addr", mem_address, 0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(10'd0, 16'h1234);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h26);
`endif
    idle(3);
    check("reload_done", load_done, 1);
    check("reload_halt", cpu_halt, 0);

    check("final_pending", exp_q.size(), 0);
    check("final_overlap", n_overlap, 0);
    check("final_bytes", n_bytes, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
